// File: rtl/if_id_pipe_buf_pkg.sv
// Shared widths, default NOP encoding and buffer state encoding for the IF->ID boundary.
package if_id_pipe_buf_pkg;

    localparam int unsigned IsizeDef    = 32;
    localparam int unsigned AsizeDef    = 32;
    localparam logic [31:0] NopInstrDef = 32'h0000_0000;

    // Number of valid entries held: EMPTY (0), ONE (main only), FULL (main + skid).
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/if_id_pipe_buf_data_slot.sv
// Instruction+PC storage slot: load-enable register, cleared to {NOP, 0} on reset or clear.
module if_id_pipe_buf_data_slot #(
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        PC_W      = 32,
    parameter logic [INSTR_W-1:0] CLR_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               ld_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;

    // Clear wins over load; data only moves on an explicit load so idle-bus garbage stays out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= CLR_INSTR;
            pc_q    <= '0;
        end else if (clr_i) begin
            instr_q <= CLR_INSTR;
            pc_q    <= '0;
        end else if (ld_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_id_pipe_buf.sv
// IF->ID pipeline buffer: 2-entry skid buffer with valid/ready on both sides, registered
// if_ready and a synchronous flush for fetch redirects.
module if_id_pipe_buf
    import if_id_pipe_buf_pkg::*;
#(
    parameter int unsigned      ISIZE     = IsizeDef,
    parameter int unsigned      ASIZE     = AsizeDef,
    parameter logic [ISIZE-1:0] NOP_INSTR = ISIZE'(NopInstrDef)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [ISIZE-1:0] if_instr,
    input  logic [ASIZE-1:0] if_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [ISIZE-1:0] id_instr,
    output logic [ASIZE-1:0] id_pc
);

    buf_state_e state_q, state_d;
    logic       id_valid_q;
    logic       if_ready_q;

    logic push, pop;
    logic main_ld, main_clr, main_from_skid;
    logic skid_ld, skid_clr;

    logic [ISIZE-1:0] main_instr_d, skid_instr_q;
    logic [ASIZE-1:0] main_pc_d, skid_pc_q;

    assign push = if_valid & if_ready_q;
    assign pop  = id_valid_q & id_ready;

    // Next-state and slot control decode; flush overrides any push/pop in the same cycle.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = StEmpty;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        main_ld = 1'b1;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        state_d = StFull;
                        skid_ld = 1'b1;
                    end else if (push && pop) begin
                        main_ld = 1'b1;
                    end else if (pop) begin
                        // Draining the last entry puts NOP/0 back on the decode side.
                        state_d  = StEmpty;
                        main_clr = 1'b1;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_d        = StOne;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d  = StEmpty;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // Main slot refills from skid when it exists, otherwise straight from fetch.
    always_comb begin
        main_instr_d = if_instr;
        main_pc_d    = if_pc;
        if (main_from_skid) begin
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
        end
    end

    // State register plus flopped decodes so both handshake outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            id_valid_q <= 1'b0;
            if_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            id_valid_q <= (state_d != StEmpty);
            if_ready_q <= (state_d != StFull);
        end
    end

    if_id_pipe_buf_data_slot #(
        .INSTR_W   (ISIZE),
        .PC_W      (ASIZE),
        .CLR_INSTR (NOP_INSTR)
    ) u_main_slot (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (main_clr),
        .ld_i    (main_ld),
        .instr_i (main_instr_d),
        .pc_i    (main_pc_d),
        .instr_o (id_instr),
        .pc_o    (id_pc)
    );

    if_id_pipe_buf_data_slot #(
        .INSTR_W   (ISIZE),
        .PC_W      (ASIZE),
        .CLR_INSTR (NOP_INSTR)
    ) u_skid_slot (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (skid_clr),
        .ld_i    (skid_ld),
        .instr_i (if_instr),
        .pc_i    (if_pc),
        .instr_o (skid_instr_q),
        .pc_o    (skid_pc_q)
    );

    assign id_valid = id_valid_q;
    assign if_ready = if_ready_q;

endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Randomised and directed bench for if_id_pipe_buf against a queue-based FIFO model.
module tb_if_id_pipe_buf;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model: entries held, oldest first, as {instr, pc}.
    logic [63:0] mq[$];

    if_id_pipe_buf #(
        .ISIZE     (32),
        .ASIZE     (32),
        .NOP_INSTR (Nop)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_instr (id_instr),
        .id_pc    (id_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : {Nop, 32'h0};
        check({tag, ".id_valid"}, 64'(id_valid), 64'(mq.size() != 0));
        check({tag, ".if_ready"}, 64'(if_ready), 64'(mq.size() < 2));
        check({tag, ".id_instr"}, 64'(id_instr), 64'(head[63:32]));
        check({tag, ".id_pc"}, 64'(id_pc), 64'(head[31:0]));
    endtask

    // Called at posedge+1: drive, check current outputs, advance model, cross the edge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic rdy, input logic fl);
        logic push, pop;
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        id_ready = rdy;
        flush    = fl;
        #1;
        check_outputs(tag);
        push = v && (mq.size() < 2);
        pop  = rdy && (mq.size() != 0);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({ins, pc});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        id_ready = 1'b0;
        #2;
        check("reset.id_valid", 64'(id_valid), 64'(0));
        check("reset.if_ready", 64'(if_ready), 64'(1));
        check("reset.id_instr", 64'(id_instr), 64'(Nop));
        check("reset.id_pc", 64'(id_pc), 64'(0));
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming with decoder always ready.
        cycle("stream", 1'b1, 32'h00A0_0093, 32'h100, 1'b1, 1'b0);
        cycle("stream", 1'b1, 32'h00B0_0113, 32'h104, 1'b1, 1'b0);
        for (int k = 2; k < 8; k++) begin
            cycle("stream", 1'b1, 32'h00A0_0093 + 32'(k) * 32'h0010_0080, 32'h100 + 32'(4 * k),
                  1'b1, 1'b0);
        end
        cycle("stream", 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 1'b1, 1'b0);
        cycle("stream", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall into skid, then release.
        cycle("skid", 1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
        cycle("skid", 1'b1, 32'h22, 32'h4, 1'b0, 1'b0);
        cycle("skid", 1'b1, 32'h99, 32'h8, 1'b0, 1'b0);
        check("skid.full_hold", 64'(id_instr), 64'(32'h11));
        cycle("skid", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("skid", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("skid", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full with a live push: 0x33 must be dropped.
        cycle("flush", 1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h22, 32'h4, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h33, 32'h8, 1'b1, 1'b1);
        check("flush.id_valid", 64'(id_valid), 64'(0));
        check("flush.if_ready", 64'(if_ready), 64'(1));
        cycle("flush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Push and pop together while holding one entry.
        cycle("pushpop", 1'b1, 32'h44, 32'h10, 1'b0, 1'b0);
        cycle("pushpop", 1'b1, 32'h55, 32'h14, 1'b1, 1'b0);
        check("pushpop.id_instr", 64'(id_instr), 64'(32'h55));
        check("pushpop.if_ready", 64'(if_ready), 64'(1));
        cycle("pushpop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while full takes effect before the next edge.
        cycle("arst", 1'b1, 32'hAA, 32'h20, 1'b0, 1'b0);
        cycle("arst", 1'b1, 32'hBB, 32'h24, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("arst.id_valid", 64'(id_valid), 64'(0));
        check("arst.if_ready", 64'(if_ready), 64'(1));
        check("arst.id_instr", 64'(id_instr), 64'(Nop));
        check("arst.id_pc", 64'(id_pc), 64'(0));
        mq.delete();
        #1;
        rst = 1'b0;
        cycle("arst", 1'b1, 32'hCC, 32'h28, 1'b1, 1'b0);
        cycle("arst", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic; inputs carry garbage when not valid.
        for (int n = 0; n < 10000; n++) begin
            cycle("rand", $urandom_range(0, 99) < 65, $urandom, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 3);
        end
        cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
